// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer with a writable branch-target LUT.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int LUT_AW     = 5,
    parameter int START_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              jump_en,
    input  logic              branch_en,
    input  logic              ZERO,
    input  logic [LUT_AW-1:0] LutIdx,
    input  logic              LutWe,
    input  logic [LUT_AW-1:0] LutWAddr,
    input  logic [PC_W-1:0]   LutWData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic [15:0]       CycleCnt
);

    localparam int LUT_N = 2 ** LUT_AW;
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   lut_q [LUT_N];
    logic [PC_W-1:0]   lut_d [LUT_N];
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   target_s;

    // Jump target is read from the LUT contents before any same-cycle write.
    assign target_s = lut_q[LutIdx];

    // Next-state, next-PC and LUT write logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lut_d   = lut_q;
        if (LutWe) begin
            lut_d[LutWAddr] = LutWData;
        end else begin
            lut_d = lut_q;
        end
        case (state_q)
            ST_IDLE: begin
                pc_d = START_PC;
                if (Start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_DONE;
                end else if (jump_en) begin
                    pc_d = target_s;
                end else if (branch_en && ZERO) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC;
            end
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State, PC, status and LUT registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of edges spent in RUN; cleared by an accepted Start.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_RUN) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (Start) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Cycle counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CycleCnt = cnt_q;
`else
    assign CycleCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch sequencer.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset, Start, Halt, jump_en, branch_en, ZERO, LutWe;
    logic [4:0]  LutIdx, LutWAddr;
    logic [9:0]  LutWData, ProgCtr;
    logic        Running, Done;
    logic [15:0] CycleCnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0=idle, 1=run, 2=done.
    int m_mode;
    int m_pc;
    int m_cnt;
    int m_lut [32];

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .jump_en(jump_en), .branch_en(branch_en), .ZERO(ZERO),
        .LutIdx(LutIdx), .LutWe(LutWe), .LutWAddr(LutWAddr), .LutWData(LutWData),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        Reset = 1'b0; Start = 1'b0; Halt = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
        ZERO = 1'b0; LutIdx = 5'd0; LutWe = 1'b0; LutWAddr = 5'd0; LutWData = 10'd0;
    endtask

    task automatic model_update();
        int target;
        if (Reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
            for (int i = 0; i < 32; i++) m_lut[i] = 0;
        end else begin
            target = m_lut[LutIdx];
            if (LutWe) m_lut[LutWAddr] = int'(LutWData);
            if (m_mode == 0) begin
                if (Start) begin m_mode = 1; m_cnt = 0; end
            end else if (m_mode == 1) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (Halt) m_mode = 2;
                else if (jump_en || (branch_en && ZERO)) m_pc = target;
                else m_pc = (m_pc + 1) % 1024;
            end else begin
                if (Start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
            end
        end
    endtask

    // Apply current inputs for one edge, then compare every output with the model.
    task automatic tick(input string tag);
        model_update();
        @(posedge Clk);
        @(negedge Clk);
        check_eq({tag, ".pc"}, 32'(ProgCtr), 32'(m_pc));
        check_eq({tag, ".run"}, 32'(Running), 32'(m_mode == 1));
        check_eq({tag, ".done"}, 32'(Done), 32'(m_mode == 2));
`ifdef FETCH_CYCLE_CNT_EN
        check_eq({tag, ".cnt"}, 32'(CycleCnt), 32'(m_cnt));
`else
        check_eq({tag, ".cnt"}, 32'(CycleCnt), 32'd0);
`endif
        clear_in();
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
        LutWe = 1'b1; LutWAddr = a; LutWData = d;
    endtask

    initial begin
        clear_in();
        m_mode = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
        @(negedge Clk);

        // T1: reset, then jump through every LUT entry expecting zero.
        Reset = 1'b1; tick("t1_rst0");
        Reset = 1'b1; tick("t1_rst1");
        check_eq("t1_pc", 32'(ProgCtr), 32'd0);
        check_eq("t1_run", 32'(Running), 32'd0);
        Start = 1'b1; tick("t1_start");
        for (int i = 0; i < 32; i++) begin
            jump_en = 1'b1; LutIdx = 5'(i); tick("t1_lut");
            check_eq("t1_lut_zero", 32'(ProgCtr), 32'd0);
        end
        Reset = 1'b1; tick("t1_rst2");

        // T2: sequential stepping and halt.
        Start = 1'b1; tick("t2_start");
        check_eq("t2_pc0", 32'(ProgCtr), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick("t2_seq");
            check_eq("t2_pcn", 32'(ProgCtr), 32'(i));
        end
        Halt = 1'b1; tick("t2_halt");
        check_eq("t2_done", 32'(Done), 32'd1);
        check_eq("t2_pc_hold", 32'(ProgCtr), 32'd5);
`ifdef FETCH_CYCLE_CNT_EN
        check_eq("t2_cnt", 32'(CycleCnt), 32'd6);
`endif
        tick("t2_done_hold");

        // T3: jump and branch.
        lut_write(5'd3, 10'h120); tick("t3_wr");
        Start = 1'b1; tick("t3_start");
        jump_en = 1'b1; LutIdx = 5'd3; tick("t3_jump");
        check_eq("t3_jump_pc", 32'(ProgCtr), 32'h120);
        branch_en = 1'b1; ZERO = 1'b0; LutIdx = 5'd3; tick("t3_nt");
        check_eq("t3_nt_pc", 32'(ProgCtr), 32'h121);
        branch_en = 1'b1; ZERO = 1'b1; LutIdx = 5'd3; tick("t3_tk");
        check_eq("t3_tk_pc", 32'(ProgCtr), 32'h120);

        // T4: collisions.
        Halt = 1'b1; jump_en = 1'b1; LutIdx = 5'd0; tick("t4_halt_jump");
        check_eq("t4_pc_hold", 32'(ProgCtr), 32'h120);
        Start = 1'b1; tick("t4_restart");
        lut_write(5'd3, 10'h050); jump_en = 1'b1; LutIdx = 5'd3; tick("t4_wr_jump");
        check_eq("t4_old_entry", 32'(ProgCtr), 32'h120);
        jump_en = 1'b1; LutIdx = 5'd3; tick("t4_new_jump");
        check_eq("t4_new_entry", 32'(ProgCtr), 32'h050);

        // T5: wrap and restart.
        lut_write(5'd1, 10'h3FF); tick("t5_wr");
        jump_en = 1'b1; LutIdx = 5'd1; tick("t5_jump");
        check_eq("t5_top", 32'(ProgCtr), 32'h3FF);
        tick("t5_wrap");
        check_eq("t5_wrap_pc", 32'(ProgCtr), 32'h000);
        Halt = 1'b1; tick("t5_halt");
        Start = 1'b1; tick("t5_restart");
        check_eq("t5_restart_pc", 32'(ProgCtr), 32'd0);
        Start = 1'b1; tick("t5_start_in_run");
        check_eq("t5_ign_pc", 32'(ProgCtr), 32'd1);

        // T6: reset mid-RUN.
        lut_write(5'd2, 10'h077); tick("t6_wr");
        jump_en = 1'b1; LutIdx = 5'd2; tick("t6_jump");
        check_eq("t6_pc77", 32'(ProgCtr), 32'h077);
        Reset = 1'b1; jump_en = 1'b1; LutIdx = 5'd3; lut_write(5'd4, 10'h111); tick("t6_rst");
        check_eq("t6_idle_pc", 32'(ProgCtr), 32'd0);
        check_eq("t6_idle_run", 32'(Running), 32'd0);
        Start = 1'b1; tick("t6_start");
        jump_en = 1'b1; LutIdx = 5'd2; tick("t6_cleared");
        check_eq("t6_lut_zero", 32'(ProgCtr), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            Start     = ($urandom_range(0, 9) == 0);
            Halt      = ($urandom_range(0, 24) == 0);
            jump_en   = ($urandom_range(0, 5) == 0);
            branch_en = ($urandom_range(0, 4) == 0);
            ZERO      = 1'($urandom);
            LutIdx    = 5'($urandom);
            LutWe     = ($urandom_range(0, 3) == 0);
            LutWAddr  = 5'($urandom);
            LutWData  = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
